// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_pkg : frame constants, receiver states and parity helper      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package serial_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP1     = 3'd4,
    STOP2     = 3'd5,
    WAIT_IDLE = 3'd6
  } rx_state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] i_byte);
    return ^i_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer, resets to 1 (idle serial line)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | receiver : oversampled serial receive stage (8 data, even parity,    |
// |            2 stop bits) with parity/framing error reporting          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module receiver
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 dataIn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 valid,
  output logic                 parityError,
  output logic                 framingError,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] c_HALF     = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 w_rxs;
  logic                 w_stop2_ferr;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_done;

  sync_2ff u_sync (
    .clk (clk),
    .rst (reset),
    .i_d (dataIn),
    .o_q (w_rxs)
  );

  assign w_stop2_ferr = r_ferr | ~w_rxs;
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_done       <= 1'b0;
      dataOut      <= '0;
      valid        <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
    end else begin
      valid <= 1'b0;
      // Publish one clk after the STOP2 sample, independent of tick.
      if (r_done) begin
        dataOut      <= r_shift;
        parityError  <= r_perr;
        framingError <= r_ferr;
        valid        <= 1'b1;
        r_done       <= 1'b0;
      end

      if (tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rxs) begin
              r_state <= START;
              r_cnt   <= '0;
            end
          end
          START: begin
            if (r_cnt == c_HALF) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= w_rxs ? IDLE : DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DATA: begin
            if (r_cnt == c_LAST) begin
              r_cnt   <= '0;
              r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
              r_idx   <= r_idx + 1'b1;
              if (r_idx == c_IDX_LAST) r_state <= PARITY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (r_cnt == c_LAST) begin
              r_cnt   <= '0;
              r_perr  <= w_rxs ^ calc_parity(r_shift);
              r_state <= STOP1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STOP1: begin
            if (r_cnt == c_LAST) begin
              r_cnt   <= '0;
              r_ferr  <= ~w_rxs;
              r_state <= STOP2;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STOP2: begin
            if (r_cnt == c_LAST) begin
              r_cnt   <= '0;
              r_ferr  <= w_stop2_ferr;
              r_done  <= 1'b1;
              r_state <= w_stop2_ferr ? WAIT_IDLE : IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          WAIT_IDLE: begin
            // A line stuck low must rise before another start is accepted.
            r_cnt <= r_cnt + 1'b1;
            if (w_rxs) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
